// File: rtl/ring_counter_param.sv
// ring_counter_param
//   Parametrised shift-register counter: one-hot ring or Johnson (twisted
//   ring) sequence, selectable at runtime, with bidirectional shifting,
//   parallel load, a binary step index, a full-cycle wrap pulse and
//   illegal-pattern detection with optional restart.
//
// Parameters
//   WIDTH        counter width, 2..64
//   SELF_CORRECT 1: an enabled shift from an illegal pattern restarts the
//                counter; 0: the illegal pattern shifts unchanged
//   SW           step index width (derived, do not override)
//
// Ports
//   clk      in   clock, rising edge
//   init     in   asynchronous active-high reset
//   en       in   shift enable
//   dir      in   0 = shift toward MSB, 1 = shift toward LSB
//   mode     in   0 = ring, 1 = Johnson
//   load     in   synchronous load of load_val (beats en)
//   load_val in   pattern to load
//   count    out  registered counter pattern
//   step     out  registered step index within the current cycle
//   wrap     out  registered one-cycle pulse when a shift lands on step 0
//   err      out  combinational: count is illegal for the current mode
//
// Control semantics: inputs are level-sampled on each rising edge with
// priority init > load > en; there is no handshake. count itself is the
// complete sequencing state and is exposed directly.
module ring_counter_param #(
  parameter int WIDTH        = 8,
  parameter int SELF_CORRECT = 1,
  parameter int SW           = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             init,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [SW-1:0]    step,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RING_RST = {1'b1, {(WIDTH-1){1'b0}}};
  // Moduli are held one bit wider than step so that 2*WIDTH is representable.
  localparam logic [SW:0]      M_RING   = (SW+1)'(WIDTH);
  localparam logic [SW:0]      M_JOHN   = (SW+1)'(2 * WIDTH);

  logic [WIDTH-1:0] count_nxt;
  logic [SW-1:0]    step_nxt;
  logic             wrap_nxt;

  logic [WIDTH-1:0] rst_val;
  logic [WIDTH-1:0] shifted;
  logic [SW:0]      mod_m;
  logic [SW:0]      step_ext;
  logic [SW:0]      step_shift_ext;
  logic [SW-1:0]    step_shift;
  logic [WIDTH-1:0] inv;
  logic             ring_legal;
  logic             john_legal;

  assign rst_val = mode ? '0 : RING_RST;

  // ---------------------------------------------------------------------
  // Legality
  //   ring:    exactly one bit set (non-zero power of two)
  //   Johnson: a run of ones anchored at bit 0 (count+1 is a power of two
  //            or zero), or anchored at the MSB (same test on ~count);
  //            all-zero and all-ones fall out of either test.
  // ---------------------------------------------------------------------
  always_comb begin
    inv        = ~count;
    ring_legal = (count != '0) && ((count & (count - ONE)) == '0);
    john_legal = ((count & (count + ONE)) == '0) ||
                 ((inv & (inv + ONE)) == '0);
    err        = mode ? !john_legal : !ring_legal;
  end

  // ---------------------------------------------------------------------
  // Shift pattern and step arithmetic for an enabled, uncorrected edge.
  // Step out of range (after a mode change) is folded back: forward goes
  // to 0, backward to M-1.
  // ---------------------------------------------------------------------
  always_comb begin
    shifted        = count;
    mod_m          = mode ? M_JOHN : M_RING;
    step_ext       = {1'b0, step};
    step_shift_ext = '0;
    if (!dir) begin
      shifted = {count[WIDTH-2:0], mode ? ~count[WIDTH-1] : count[WIDTH-1]};
      if (step_ext >= mod_m - 1'b1)
        step_shift_ext = '0;
      else
        step_shift_ext = step_ext + 1'b1;
    end else begin
      shifted = {mode ? ~count[0] : count[0], count[WIDTH-1:1]};
      if ((step_ext == '0) || (step_ext >= mod_m))
        step_shift_ext = mod_m - 1'b1;
      else
        step_shift_ext = step_ext - 1'b1;
    end
    step_shift = step_shift_ext[SW-1:0];
  end

  // ---------------------------------------------------------------------
  // Next state: load > correction/shift > hold
  // ---------------------------------------------------------------------
  always_comb begin
    count_nxt = count;
    step_nxt  = step;
    wrap_nxt  = 1'b0;
    if (load) begin
      count_nxt = load_val;
      step_nxt  = '0;
    end else if (en) begin
      if ((SELF_CORRECT != 0) && err) begin
        // Restart replaces the shift and never pulses wrap.
        count_nxt = rst_val;
        step_nxt  = '0;
      end else begin
        count_nxt = shifted;
        step_nxt  = step_shift;
        wrap_nxt  = (step_shift == '0);
      end
    end
  end

  // ---------------------------------------------------------------------
  // State register. The reset pattern follows mode while init is high.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      count <= rst_val;
      step  <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      step  <= step_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: doc/ring_counter_param.md
Name: ring_counter_param

Overview:
Parametrised shift-register counter generalising the fixed 8-bit ring counter. It provides:
- WIDTH-bit ring mode (one-hot) and Johnson mode (twisted ring), selected at runtime.
- Bidirectional shifting, count enable and synchronous parallel load.
- A binary step index, a wrap pulse and illegal-state detection with optional self-correction.

It is used as a sequencer and phase generator, and as a strobe source for downstream control logic.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2 to 64.
- SELF_CORRECT, 1, 1 = an enabled shift from an illegal pattern restarts the counter; 0 = the illegal pattern shifts as-is.
- SW, $clog2(2*WIDTH), width of the step index; derived, not to be overridden.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- init  input  1  asynchronous, active-high reset.
- en  input  1  shift enable.
- dir  input  1  shift direction. 0 = toward MSB (left). 1 = toward LSB (right).
- mode  input  1  counter mode. 0 = ring. 1 = Johnson.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  pattern to load.
- count  output  WIDTH  registered counter pattern.
- step  output  SW  registered step index within the current cycle.
- wrap  output  1  registered one-cycle pulse on completion of a full cycle.
- err  output  1  combinational; 1 when count is illegal for the current mode.

Behaviour:
- Clock and reset: one clock, clk. init is asynchronous and active-high.
- Reset values, asserted immediately on init without waiting for a clock edge:
  - count = 1 << (WIDTH-1) when mode=0; count = 0 when mode=1 (mode sampled while init is high).
  - step = 0; wrap = 0.
- Priority per edge: init > load > en. With none of them active, count and step hold and wrap = 0.
- Load:
  - count <= load_val; step <= 0; wrap <= 0.
  - en is ignored in that cycle. No legality check is applied at load.
- Shift when en=1 and load=0, latency one cycle:
  - Ring, left: count <= {count[W-2:0], count[W-1]}.
  - Ring, right: count <= {count[0], count[W-1:1]}.
  - Johnson, left: count <= {count[W-2:0], ~count[W-1]}.
  - Johnson, right: count <= {~count[0], count[W-1:1]}.
- Modulus M = WIDTH in ring mode, 2*WIDTH in Johnson mode.
- Step arithmetic:
  - dir=0: step <= 0 if step >= M-1, else step+1.
  - dir=1: step <= M-1 if step == 0 or step >= M, else step-1.
- wrap <= 1 for exactly one cycle when an enabled shift (not a correction) makes the new step equal 0. Otherwise wrap <= 0.
- Legal patterns:
  - Ring: exactly one bit set.
  - Johnson: all-zero, all-ones, a contiguous run of ones anchored at bit 0, or a contiguous run of ones anchored at bit WIDTH-1.
- err = !legal(count, mode). It follows count and mode combinationally.
- Self-correction (SELF_CORRECT=1, en=1, load=0, err=1):
  - count <= mode reset value; step <= 0; wrap <= 0.
  - The correction replaces the shift in that cycle.
- SELF_CORRECT=0: the shift proceeds normally on an illegal pattern, and step counts as usual.
- Mode change mid-run: count and step are retained. err may assert. Step is brought back into range by the arithmetic rules above.
- Direction change mid-run: takes effect on the next enabled edge, with no penalty cycle.
- init mid-run: overrides load and en. count, step and wrap return to reset values at once, and wrap is never asserted on the exit from reset.

Test Plan:
- Ring left, W=8: reset -> count=8'h80, step=0. 8 enabled edges -> 01,02,04,...,40,80. step 1..7 then 0. wrap=1 only in the cycle after the 8th edge.
- Johnson left, W=8, reset with mode=1: 16 enabled edges -> 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00. wrap pulses once, at step 0. err stays 0 throughout.
- Ring right, dir=1, from reset: 80 -> 40 -> 20, step 0 -> 7 -> 6. Toggle en low for 3 edges -> count and step hold, wrap stays 0.
- Illegal ring pattern: load 8'h81 -> err=1, step=0. Next enabled edge with SELF_CORRECT=1 -> count=8'h80, step=0, wrap=0, err=0. With SELF_CORRECT=0 -> count=8'h03, err stays 1.
- Priority: load=1 and en=1 with load_val=8'h10 -> count=8'h10, step=0, no shift.
- Asynchronous reset: assert init between edges while count=8'h08, step=3 -> count=8'h80, step=0 before the next edge. Release init -> the first enabled edge gives 8'h01.
